// File: rtl/lab3_cache_pkg.sv
// rtl/lab3_cache_pkg.sv - line-width constants and FSM state type for the cache
// Purpose: words-per-line default, line/index width helpers, receive FSM states.
package lab3_cache_pkg;

  localparam int unsigned WORD_BITS      = 32;
  localparam int unsigned NWORDS_DEFAULT = 4;

  function automatic int unsigned line_bits(input int unsigned nwords);
    return WORD_BITS * nwords;
  endfunction

  function automatic int unsigned idx_bits(input int unsigned nwords);
    return $clog2(nwords);
  endfunction

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } recv_state_t;

endpackage

// File: rtl/vc_mem_msgs_pkg.sv
// rtl/vc_mem_msgs_pkg.sv - memory message types shared across vc components
// Purpose: defines the 4-byte memory response message and its type encodings.
package vc_mem_msgs_pkg;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

// File: rtl/lab3_cache_line_assembler.sv
// rtl/lab3_cache_line_assembler.sv - per-slot data and present-bit storage for one line
// Purpose: writes words into indexed slots, tracks which slots hold data.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset (clears present bits only)
//   wr_en        - write wr_data into slot wr_idx and mark it present
//   wr_idx       - slot index
//   wr_data      - 32-bit word
//   clear        - drop all present bits (line handed off)
//   present_hit  - the slot being written is already present
//   fill_done    - this write sets the last clear present bit
//   line         - concatenated slot data, slot i at [32i+31:32i]
//   count        - population count of present bits
module lab3_cache_line_assembler
  import lab3_cache_pkg::*;
#(
  parameter int p_nwords = NWORDS_DEFAULT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [idx_bits(p_nwords)-1:0]      wr_idx,
  input  logic [31:0]                        wr_data,
  input  logic                               clear,
  output logic                               present_hit,
  output logic                               fill_done,
  output logic [line_bits(p_nwords)-1:0]     line,
  output logic [idx_bits(p_nwords):0]        count
);

  localparam int CNTW = idx_bits(p_nwords) + 1;

  logic [p_nwords-1:0] present_q;
  logic [p_nwords-1:0] wr_mask;
  logic [31:0]         data_q [p_nwords];

  always_comb begin
    wr_mask = '0;
    if (wr_en) wr_mask[wr_idx] = 1'b1;
  end

  assign present_hit = |(present_q & wr_mask);
  assign fill_done   = wr_en && (&(present_q | wr_mask));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      present_q <= '0;
    else if (clear) present_q <= '0;
    else            present_q <= present_q | wr_mask;
  end

  // Data is deliberately not reset or cleared; present bits alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_idx] <= wr_data;
  end

  for (genvar i = 0; i < p_nwords; i++) begin : g_line
    assign line[32*i +: 32] = data_q[i];
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < p_nwords; i++) count = count + CNTW'(present_q[i]);
  end

endmodule

// File: rtl/lab3_cache_batch_receive.sv
// rtl/lab3_cache_batch_receive.sv - collects word responses into one cache line
// Purpose: accepts memory responses in any order, slots them by opaque index,
//   and presents the full line once every slot has been filled.
// Optional: LAB3_CACHE_BATCH_RECV_CHECK_EN enables the sticky protocol error flag.
// Ports:
//   clk, reset                        - clock, asynchronous active-high reset
//   istream_val/istream_rdy/istream_msg - memory response stream (mem_resp_4B_t)
//   ostream_val/ostream_rdy/ostream_line - assembled line stream
//   count                             - number of distinct slots filled
//   error                             - sticky duplicate/non-read error flag
module lab3_cache_batch_receive
  import vc_mem_msgs_pkg::*;
  import lab3_cache_pkg::*;
#(
  parameter int p_nwords = NWORDS_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           istream_val,
  output logic                           istream_rdy,
  input  mem_resp_4B_t                   istream_msg,
  output logic                           ostream_val,
  input  logic                           ostream_rdy,
  output logic [line_bits(p_nwords)-1:0] ostream_line,
  output logic [idx_bits(p_nwords):0]    count,
  output logic                           error
);

  localparam int IDXW = idx_bits(p_nwords);

  recv_state_t state_q, state_n;
  logic        wr_en;
  logic        clear;
  logic        present_hit;
  logic        fill_done;

  assign wr_en = istream_val && istream_rdy;

  lab3_cache_line_assembler #(.p_nwords(p_nwords)) u_asm (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_idx      (istream_msg.opaque[IDXW-1:0]),
    .wr_data     (istream_msg.data),
    .clear       (clear),
    .present_hit (present_hit),
    .fill_done   (fill_done),
    .line        (ostream_line),
    .count       (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_n;
  end

  // istream_rdy is low in FULL, so a word offered during handoff waits a cycle.
  always_comb begin
    state_n     = state_q;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    clear       = 1'b0;
    case (state_q)
      COLLECT: begin
        istream_rdy = 1'b1;
        if (fill_done) state_n = FULL;
      end
      FULL: begin
        ostream_val = 1'b1;
        if (ostream_rdy) begin
          clear   = 1'b1;
          state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

`ifdef LAB3_CACHE_BATCH_RECV_CHECK_EN
  logic error_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) error_q <= 1'b0;
    else if (wr_en && (present_hit || istream_msg.type_ != MEM_TYPE_READ)) error_q <= 1'b1;
  end
  assign error = error_q;

  logic unused_msg_bits;
  assign unused_msg_bits = ^{istream_msg.len, istream_msg.opaque[7:IDXW]};
`else
  assign error = 1'b0;

  logic unused_msg_bits;
  assign unused_msg_bits = ^{istream_msg.len, istream_msg.opaque[7:IDXW],
                             istream_msg.type_, present_hit};
`endif

endmodule

// File: tb/tb_lab3_cache_batch_receive.sv
// tb/tb_lab3_cache_batch_receive.sv - directed self-checking bench for lab3_cache_batch_receive
module tb_lab3_cache_batch_receive;
  import vc_mem_msgs_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          istream_val;
  logic          istream_rdy;
  mem_resp_4B_t  istream_msg;
  logic          ostream_val;
  logic          ostream_rdy;
  logic [127:0]  ostream_line;
  logic [2:0]    count;
  logic          error;

  int errors = 0;
  int checks = 0;

`ifdef LAB3_CACHE_BATCH_RECV_CHECK_EN
  localparam logic DUP_ERR = 1'b1;
`else
  localparam logic DUP_ERR = 1'b0;
`endif

  lab3_cache_batch_receive #(.p_nwords(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .istream_val  (istream_val),
    .istream_rdy  (istream_rdy),
    .istream_msg  (istream_msg),
    .ostream_val  (ostream_val),
    .ostream_rdy  (ostream_rdy),
    .ostream_line (ostream_line),
    .count        (count),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] d);
    istream_msg = '{type_: MEM_TYPE_READ, opaque: op, len: 2'd0, data: d};
    istream_val = 1'b1;
  endtask

  task automatic send(input logic [7:0] op, input logic [31:0] d);
    drive(op, d);
    tick();
    istream_val = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; istream_val = 1'b0; ostream_rdy = 1'b0;
    istream_msg = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (istream_rdy !== 1'b1) begin errors++; $display("FAIL reset_irdy: got %b want 1", istream_rdy); end
    checks++; if (ostream_val !== 1'b0) begin errors++; $display("FAIL reset_oval: got %b want 0", ostream_val); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
  endtask

  task automatic test_in_order();
    ostream_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(8'(i), 32'hA0 + 32'(i));
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL inorder_count%0d: got %0d want %0d", i, count, i + 1); end
      checks++; if (ostream_val !== (i == 3)) begin errors++; $display("FAIL inorder_oval%0d: got %b want %b", i, ostream_val, (i == 3)); end
    end
    checks++; if (ostream_line !== 128'h000000A3_000000A2_000000A1_000000A0) begin errors++; $display("FAIL inorder_line: got %h want 000000a3000000a2000000a1000000a0", ostream_line); end
    checks++; if (istream_rdy !== 1'b0) begin errors++; $display("FAIL inorder_full_irdy: got %b want 0", istream_rdy); end
    tick();
    checks++; if (ostream_val !== 1'b0 || istream_rdy !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL inorder_handoff: got oval=%b irdy=%b count=%0d want 0 1 0", ostream_val, istream_rdy, count); end
    ostream_rdy = 1'b0;
  endtask

  task automatic test_out_of_order();
    logic [7:0] ops [4];
    ops = '{8'd2, 8'd0, 8'd3, 8'd1};
    ostream_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], 32'hD0 + 32'(ops[i]));
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL ooo_count%0d: got %0d want %0d", i, count, i + 1); end
    end
    checks++; if (ostream_val !== 1'b1) begin errors++; $display("FAIL ooo_oval: got %b want 1", ostream_val); end
    checks++; if (ostream_line !== 128'h000000D3_000000D2_000000D1_000000D0) begin errors++; $display("FAIL ooo_line: got %h want 000000d3000000d2000000d1000000d0", ostream_line); end
    ostream_rdy = 1'b1;
    tick();
    ostream_rdy = 1'b0;
    checks++; if (ostream_val !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL ooo_handoff: got oval=%b count=%0d want 0 0", ostream_val, count); end
  endtask

  task automatic test_backpressure();
    ostream_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i), 32'hE0 + 32'(i));
    drive(8'd0, 32'hFF);
    for (int c = 0; c < 5; c++) begin
      checks++; if (istream_rdy !== 1'b0 || ostream_val !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got irdy=%b oval=%b want 0 1", c, istream_rdy, ostream_val); end
      checks++; if (ostream_line !== 128'h000000E3_000000E2_000000E1_000000E0 || count !== 3'd4) begin errors++; $display("FAIL bp_line%0d: got %h count=%0d want 000000e3000000e2000000e1000000e0 4", c, ostream_line, count); end
      tick();
    end
    istream_val = 1'b0;
    ostream_rdy = 1'b1;
    tick();
    ostream_rdy = 1'b0;
    checks++; if (ostream_val !== 1'b0 || count !== 3'd0 || istream_rdy !== 1'b1) begin errors++; $display("FAIL bp_handoff: got oval=%b count=%0d irdy=%b want 0 0 1", ostream_val, count, istream_rdy); end
  endtask

  task automatic test_duplicate();
    ostream_rdy = 1'b0;
    send(8'd1, 32'h11);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL dup_first_error: got %b want 0", error); end
    send(8'd1, 32'h22);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL dup_count: got %0d want 1", count); end
    checks++; if (error !== DUP_ERR) begin errors++; $display("FAIL dup_error: got %b want %b", error, DUP_ERR); end
    send(8'd0, 32'h10);
    send(8'd2, 32'h12);
    send(8'd3, 32'h13);
    checks++; if (ostream_val !== 1'b1 || ostream_line !== 128'h00000013_00000012_00000022_00000010) begin errors++; $display("FAIL dup_line: got oval=%b %h want 1 00000013000000120000002200000010", ostream_val, ostream_line); end
    ostream_rdy = 1'b1;
    tick();
    ostream_rdy = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    ostream_rdy = 1'b0;
    send(8'd0, 32'h55);
    send(8'd1, 32'h66);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL rst_pre_count: got %0d want 2", count); end
    reset = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_async_count: got %0d want 0", count); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (count !== 3'd0 || istream_rdy !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL rst_after: got count=%0d irdy=%b err=%b want 0 1 0", count, istream_rdy, error); end
    for (int i = 0; i < 4; i++) send(8'(i), 32'hC0 + 32'(i));
    checks++; if (ostream_val !== 1'b1 || count !== 3'd4 || ostream_line !== 128'h000000C3_000000C2_000000C1_000000C0) begin errors++; $display("FAIL rst_newline: got oval=%b count=%0d %h want 1 4 000000c3000000c2000000c1000000c0", ostream_val, count, ostream_line); end
    reset = 1'b1;
    #1;
    checks++; if (ostream_val !== 1'b0 || istream_rdy !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL rst_in_full: got oval=%b irdy=%b count=%0d want 0 1 0", ostream_val, istream_rdy, count); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    ostream_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i), 32'h70 + 32'(i));
    checks++; if (ostream_val !== 1'b1 || ostream_line !== 128'h00000073_00000072_00000071_00000070) begin errors++; $display("FAIL b2b_line_a: got oval=%b %h want 1 00000073000000720000007100000070", ostream_val, ostream_line); end
    drive(8'd0, 32'h80);
    ostream_rdy = 1'b1;
    checks++; if (istream_rdy !== 1'b0) begin errors++; $display("FAIL b2b_irdy_handoff: got %b want 0", istream_rdy); end
    tick();
    ostream_rdy = 1'b0;
    checks++; if (ostream_val !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL b2b_not_taken: got oval=%b count=%0d want 0 0", ostream_val, count); end
    tick();
    istream_val = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_taken_next: got %0d want 1", count); end
    for (int i = 1; i < 4; i++) send(8'(i), 32'h80 + 32'(i));
    checks++; if (ostream_val !== 1'b1 || ostream_line !== 128'h00000083_00000082_00000081_00000080) begin errors++; $display("FAIL b2b_line_b: got oval=%b %h want 1 00000083000000820000008100000080", ostream_val, ostream_line); end
    ostream_rdy = 1'b1;
    tick();
    ostream_rdy = 1'b0;
    checks++; if (ostream_val !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL b2b_final: got oval=%b count=%0d want 0 0", ostream_val, count); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_backpressure();
    test_duplicate();
    test_reset_mid_fill();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lab3_cache_batch_receive.md
LAB3_CACHE_BATCH_RECEIVE -- requirements
Module: lab3_cache_BatchReceive

Interface
REQ-001 The block SHALL have parameter p_nwords, default 4, meaning the number of 32-bit words per cache line; legal values are 2, 4 and 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port istream_val, input, 1 bit: a memory response is valid.
REQ-005 The block SHALL have port istream_rdy, output, 1 bit: the block accepts a memory response.
REQ-006 The block SHALL have port istream_msg, input, mem_resp_4B_t: the memory response (type_, opaque, len, data).
REQ-007 The block SHALL have port ostream_val, output, 1 bit: the assembled line is valid.
REQ-008 The block SHALL have port ostream_rdy, input, 1 bit: the cache controller consumes the line.
REQ-009 The block SHALL have port ostream_line, output, 32*p_nwords bits: the assembled line; word i occupies bits [32i+31:32i].
REQ-010 The block SHALL have port count, output, $clog2(p_nwords)+1 bits: the number of distinct words collected so far.
REQ-011 The block SHALL have port error, output, 1 bit: sticky protocol error flag.

Function
REQ-012 The block SHALL have two states: COLLECT and FULL; the reset state SHALL be COLLECT.
REQ-013 In COLLECT, istream_rdy SHALL be 1 and ostream_val SHALL be 0.
REQ-014 In FULL, istream_rdy SHALL be 0 and ostream_val SHALL be 1.
REQ-015 On a transfer (istream_val && istream_rdy), the block SHALL write data into word slot opaque[$clog2(p_nwords)-1:0] and set that slot's present bit; responses MAY arrive in any order.
REQ-016 count SHALL equal the population count of the present bits, updated in the cycle after the transfer.
REQ-017 When the transfer sets the last clear present bit, the state SHALL become FULL on the next edge, so ostream_val rises exactly 1 cycle after the final accepted word; there SHALL be no combinational path from istream to ostream.
REQ-018 A response to an already-present slot SHALL overwrite that slot's data and SHALL NOT change count.
REQ-019 In FULL with ostream_rdy=1, the block SHALL clear all present bits and return to COLLECT on that edge; ostream_line SHALL be held stable while ostream_val=1 and ostream_rdy=0.
REQ-020 The block SHALL NOT accept a new word in the same cycle as the line handoff; the earliest next acceptance SHALL be the following cycle.
REQ-021 Data registers SHALL NOT be cleared on handoff; ostream_line SHALL be meaningful only while ostream_val=1.

Reset
REQ-022 Asserting reset SHALL immediately force state=COLLECT, present bits=0, count=0, error=0, ostream_val=0 and istream_rdy=1 after deassertion; data registers need not reset.
REQ-023 A partially collected line SHALL be discarded by reset at any time, including in FULL before handoff.

Configuration
REQ-024 With LAB3_CACHE_BATCH_RECV_CHECK_EN defined, error SHALL be set, one cycle after the offending transfer and held until reset, by a duplicate-slot response or a response with type_ not equal to read; the data SHALL still be written.
REQ-025 Without LAB3_CACHE_BATCH_RECV_CHECK_EN, error SHALL be tied to 0 and no checking logic SHALL exist.

Structure
REQ-026 Line-width constants (words per line, line bits, index bits) SHALL live in the shared package lab3_cache_pkg; mem_resp_4B_t SHALL come from the existing vc memory-message definitions.
REQ-027 The present-bit/data storage MAY be a single sub-module lab3_cache_LineAssembler; the FSM SHALL stay in the top module.

Verification
REQ-028 The bench SHALL cover in-order fill: opaque 0..3 with data 0xA0..0xA3, ostream_rdy=1 -> ostream_val one cycle after the 4th word, line 0x000000A3_000000A2_000000A1_000000A0, then COLLECT.
REQ-029 The bench SHALL cover out-of-order fill: opaque 2,0,3,1 -> same line placement by index; count steps 1,2,3,4.
REQ-030 The bench SHALL cover backpressure: ostream_rdy=0 for 5 cycles in FULL -> istream_rdy=0, line stable, handoff on the first ostream_rdy=1.
REQ-031 The bench SHALL cover duplicates (check enabled): opaque 1 twice (0x11 then 0x22) -> count=1, slot1=0x22, error=1 next cycle; with the check disabled, error stays 0.
REQ-032 The bench SHALL cover reset mid-fill: 2 words accepted, reset pulsed -> count=0, a new 4-word fill produces only new data.
REQ-033 The bench SHALL cover back-to-back lines: the second line's first word is offered during handoff -> it is not accepted until the next cycle, and both lines are correct.
